// File: rtl/pong_match_ctrl.sv
// Match sequencer for the ping-pong game: serve timing, rally speed, scoring and game-over.
// Buttons are synchronised and edge-detected here; hit/miss/end_of_frame arrive in-domain.
module pong_match_ctrl #(
  parameter int WIN_SCORE          = 7,
  parameter int SCORE_W            = 7,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_HOLD_FRAMES  = 90,
  parameter int HITS_PER_LEVEL     = 4,
  parameter int MAX_LEVEL          = 7
) (
  input  logic               i_pixel_clk,
  input  logic               i_rst_n,
  input  logic               i_end_of_frame,
  input  logic               i_button_start,
  input  logic               i_button_pause,
  input  logic               i_hit_p1,
  input  logic               i_hit_p2,
  input  logic               i_miss_p1,
  input  logic               i_miss_p2,
  output logic               o_ball_run,
  output logic               o_ball_recenter,
  output logic               o_serve_dir,
  output logic [2:0]         o_speed_level,
  output logic [SCORE_W-1:0] o_p1_score,
  output logic [SCORE_W-1:0] o_p2_score,
  output logic               o_game_over,
  output logic               o_winner,
  output logic [2:0]         o_state_dbg
);

  localparam int FRAME_MAX = (SERVE_DELAY_FRAMES > POINT_HOLD_FRAMES) ?
                             SERVE_DELAY_FRAMES : POINT_HOLD_FRAMES;
  localparam int FRAME_W   = $clog2(FRAME_MAX + 1);
  localparam int HIT_W     = $clog2(HITS_PER_LEVEL + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SERVE_WAIT = 3'd1,
    S_RALLY      = 3'd2,
    S_POINT      = 3'd3,
    S_PAUSED     = 3'd4,
    S_GAME_OVER  = 3'd5
  } state_t;

  state_t               r_state, w_state_nxt;
  state_t               r_saved_state, w_saved_nxt;
  logic [1:0]           r_start_sync, r_pause_sync;
  logic                 r_start_prev, r_pause_prev;
  logic [FRAME_W-1:0]   r_frame_cnt, w_frame_nxt;
  logic [HIT_W-1:0]     r_hit_cnt, w_hit_nxt;
  logic [2:0]           r_speed, w_speed_nxt;
  logic [SCORE_W-1:0]   r_p1_score, w_p1_nxt;
  logic [SCORE_W-1:0]   r_p2_score, w_p2_nxt;
  logic                 r_serve_dir, w_serve_nxt;
  logic                 r_recenter, w_recenter_nxt;
  logic                 w_start_press, w_pause_press, w_start_ok;

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] v);
    return (v >= SCORE_W'(WIN_SCORE)) ? v : v + SCORE_W'(1);
  endfunction

  function automatic logic [2:0] level_inc(input logic [2:0] v);
    return (v >= 3'(MAX_LEVEL)) ? v : v + 3'd1;
  endfunction

  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_start_sync <= 2'b00;
      r_pause_sync <= 2'b00;
      r_start_prev <= 1'b0;
      r_pause_prev <= 1'b0;
    end else begin
      r_start_sync <= {r_start_sync[0], i_button_start};
      r_pause_sync <= {r_pause_sync[0], i_button_pause};
      r_start_prev <= r_start_sync[1];
      r_pause_prev <= r_pause_sync[1];
    end
  end

  assign w_start_press = r_start_sync[1] & ~r_start_prev;
  assign w_pause_press = r_pause_sync[1] & ~r_pause_prev;
  assign w_start_ok    = w_start_press & ~w_pause_press;

  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_saved_state <= S_IDLE;
      r_frame_cnt   <= '0;
      r_hit_cnt     <= '0;
      r_speed       <= 3'd0;
      r_p1_score    <= '0;
      r_p2_score    <= '0;
      r_serve_dir   <= 1'b1;
      r_recenter    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_saved_state <= w_saved_nxt;
      r_frame_cnt   <= w_frame_nxt;
      r_hit_cnt     <= w_hit_nxt;
      r_speed       <= w_speed_nxt;
      r_p1_score    <= w_p1_nxt;
      r_p2_score    <= w_p2_nxt;
      r_serve_dir   <= w_serve_nxt;
      r_recenter    <= w_recenter_nxt;
    end
  end

  // Recenter is registered on every entry into SERVE_WAIT except a return from pause.
  always_comb begin
    w_state_nxt    = r_state;
    w_saved_nxt    = r_saved_state;
    w_frame_nxt    = r_frame_cnt;
    w_hit_nxt      = r_hit_cnt;
    w_speed_nxt    = r_speed;
    w_p1_nxt       = r_p1_score;
    w_p2_nxt       = r_p2_score;
    w_serve_nxt    = r_serve_dir;
    w_recenter_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt    = S_SERVE_WAIT;
          w_frame_nxt    = '0;
          w_recenter_nxt = 1'b1;
        end
      end
      S_SERVE_WAIT: begin
        if (w_pause_press) begin
          w_state_nxt = S_PAUSED;
          w_saved_nxt = S_SERVE_WAIT;
        end else if (i_end_of_frame) begin
          if (r_frame_cnt == FRAME_W'(SERVE_DELAY_FRAMES - 1)) begin
            w_state_nxt = S_RALLY;
            w_frame_nxt = '0;
          end else begin
            w_frame_nxt = r_frame_cnt + FRAME_W'(1);
          end
        end
      end
      S_RALLY: begin
        if (w_pause_press) begin
          w_state_nxt = S_PAUSED;
          w_saved_nxt = S_RALLY;
        end else if (i_miss_p1 && i_miss_p2) begin
          w_state_nxt    = S_SERVE_WAIT;
          w_recenter_nxt = 1'b1;
        end else if (i_miss_p1) begin
          w_p2_nxt    = score_inc(r_p2_score);
          w_serve_nxt = 1'b0;
          w_state_nxt = S_POINT;
        end else if (i_miss_p2) begin
          w_p1_nxt    = score_inc(r_p1_score);
          w_serve_nxt = 1'b1;
          w_state_nxt = S_POINT;
        end else if (i_hit_p1 || i_hit_p2) begin
          if (r_hit_cnt == HIT_W'(HITS_PER_LEVEL - 1)) begin
            w_hit_nxt   = '0;
            w_speed_nxt = level_inc(r_speed);
          end else begin
            w_hit_nxt = r_hit_cnt + HIT_W'(1);
          end
        end
      end
      S_POINT: begin
        w_speed_nxt = 3'd0;
        w_hit_nxt   = '0;
        if (i_end_of_frame) begin
          if (r_frame_cnt == FRAME_W'(POINT_HOLD_FRAMES - 1)) begin
            w_frame_nxt = '0;
            if (r_p1_score == SCORE_W'(WIN_SCORE) || r_p2_score == SCORE_W'(WIN_SCORE)) begin
              w_state_nxt = S_GAME_OVER;
            end else begin
              w_state_nxt    = S_SERVE_WAIT;
              w_recenter_nxt = 1'b1;
            end
          end else begin
            w_frame_nxt = r_frame_cnt + FRAME_W'(1);
          end
        end
      end
      S_PAUSED: begin
        if (w_pause_press) begin
          w_state_nxt = r_saved_state;
        end
      end
      S_GAME_OVER: begin
        if (w_start_ok) begin
          w_p1_nxt       = '0;
          w_p2_nxt       = '0;
          w_serve_nxt    = 1'b1;
          w_frame_nxt    = '0;
          w_state_nxt    = S_SERVE_WAIT;
          w_recenter_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_ball_run      = (r_state == S_RALLY);
  assign o_ball_recenter = r_recenter;
  assign o_serve_dir     = r_serve_dir;
  assign o_speed_level   = r_speed;
  assign o_p1_score      = r_p1_score;
  assign o_p2_score      = r_p2_score;
  assign o_game_over     = (r_state == S_GAME_OVER);
  assign o_winner        = o_game_over & (r_p2_score == SCORE_W'(WIN_SCORE));
  assign o_state_dbg     = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed match flow with randomised rallies, scored against
// a point/rally-level model of the game rules.
module tb_pong_match_ctrl;
  localparam int WIN  = 3;
  localparam int SW   = 7;
  localparam int SD   = 60;
  localparam int PH   = 90;
  localparam int HPL  = 4;
  localparam int MAXL = 7;

  logic          clk = 1'b0, rst_n = 1'b0, eof = 1'b0;
  logic          bst = 1'b0, bpa = 1'b0;
  logic          h1 = 1'b0, h2 = 1'b0, m1 = 1'b0, m2 = 1'b0;
  logic          run, rc, dir, go, win;
  logic [2:0]    spd, st;
  logic [SW-1:0] p1, p2;

  int   n_cmp = 0, n_bad = 0, rc_cnt = 0;
  int   exp_p1 = 0, exp_p2 = 0, exp_dir = 1, hits = 0;
  logic entry_rc;

  pong_match_ctrl #(.WIN_SCORE(WIN), .SCORE_W(SW), .SERVE_DELAY_FRAMES(SD),
                    .POINT_HOLD_FRAMES(PH), .HITS_PER_LEVEL(HPL), .MAX_LEVEL(MAXL)) dut (
    .i_pixel_clk(clk), .i_rst_n(rst_n), .i_end_of_frame(eof),
    .i_button_start(bst), .i_button_pause(bpa),
    .i_hit_p1(h1), .i_hit_p2(h2), .i_miss_p1(m1), .i_miss_p2(m2),
    .o_ball_run(run), .o_ball_recenter(rc), .o_serve_dir(dir), .o_speed_level(spd),
    .o_p1_score(p1), .o_p2_score(p2), .o_game_over(go), .o_winner(win), .o_state_dbg(st)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rc === 1'b1) rc_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int lvl(input int h);
    return ((h / HPL) > MAXL) ? MAXL : (h / HPL);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      repeat (3) cyc();
      eof = 1'b1; cyc(); eof = 1'b0;
    end
  endtask

  task automatic press(input bit is_pause, input logic [2:0] target, input string tag);
    int k = 0;
    if (is_pause) bpa = 1'b1; else bst = 1'b1;
    while (st !== target && k < 8) begin cyc(); k++; end
    entry_rc = rc;
    chk(tag, 32'(st), 32'(target));
    bpa = 1'b0; bst = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic serve();
    frames(SD - 1);
    repeat (3) cyc();
    chk("serve_hold_run", 32'(run), 0);
    chk("serve_hold_state", 32'(st), 1);
    eof = 1'b1; cyc(); eof = 1'b0;
    chk("serve_run_rise", 32'(run), 1);
    chk("serve_state", 32'(st), 2);
  endtask

  task automatic do_hits(input int n, input bit alt);
    for (int i = 0; i < n; i++) begin
      if (alt) begin h1 = (i % 2 == 0); h2 = (i % 2 != 0); end
      else if ($urandom_range(0, 1) == 0) h1 = 1'b1; else h2 = 1'b1;
      cyc();
      h1 = 1'b0; h2 = 1'b0;
      hits++;
      chk("speed_level", 32'(spd), 32'(lvl(hits)));
      repeat ($urandom_range(0, 2)) cyc();
    end
  endtask

  task automatic miss(input int who);
    if (who == 1) m1 = 1'b1; else m2 = 1'b1;
    cyc();
    m1 = 1'b0; m2 = 1'b0;
    if (who == 1) begin exp_p2++; exp_dir = 0; end
    else begin exp_p1++; exp_dir = 1; end
    hits = 0;
    chk("p1_score", 32'(p1), 32'(exp_p1));
    chk("p2_score", 32'(p2), 32'(exp_p2));
    chk("serve_dir", 32'(dir), 32'(exp_dir));
    chk("point_run", 32'(run), 0);
    chk("point_state", 32'(st), 3);
    cyc();
    chk("point_speed_clr", 32'(spd), 0);
  endtask

  task automatic point_hold();
    int nxt;
    nxt = (exp_p1 == WIN || exp_p2 == WIN) ? 5 : 1;
    frames(PH - 1);
    repeat (3) cyc();
    chk("hold_state", 32'(st), 3);
    eof = 1'b1; cyc(); eof = 1'b0;
    chk("after_hold_state", 32'(st), 32'(nxt));
    if (nxt == 5) begin
      chk("game_over", 32'(go), 1);
      chk("winner", 32'(win), 32'(exp_p2 == WIN));
    end
  endtask

  initial begin
    int rc0, n, who;

    repeat (3) cyc();
    chk("rst_state", 32'(st), 0);
    chk("rst_run", 32'(run), 0);
    chk("rst_rc", 32'(rc), 0);
    chk("rst_dir", 32'(dir), 1);
    chk("rst_speed", 32'(spd), 0);
    chk("rst_p1", 32'(p1), 0);
    chk("rst_p2", 32'(p2), 0);
    chk("rst_go", 32'(go), 0);
    chk("rst_win", 32'(win), 0);
    rst_n = 1'b1;
    repeat (2) cyc();

    m1 = 1'b1; cyc(); m1 = 1'b0; cyc();
    chk("idle_miss_ignored", 32'(p2), 0);

    rc0 = rc_cnt;
    press(1'b0, 3'd1, "start_from_idle");
    chk("recenter_at_entry", 32'(entry_rc), 1);
    m2 = 1'b1; cyc(); m2 = 1'b0;
    chk("serve_wait_miss_ignored", 32'(p1), 0);
    serve();
    chk("recenter_once", 32'(rc_cnt - rc0), 1);

    do_hits(40, 1'b1);
    chk("speed_saturated", 32'(spd), MAXL);
    miss(2);
    point_hold();

    frames(30);
    press(1'b1, 3'd4, "pause_serve_wait");
    chk("paused_run", 32'(run), 0);
    h1 = 1'b1; cyc(); h1 = 1'b0;
    m1 = 1'b1; cyc(); m1 = 1'b0;
    m2 = 1'b1; cyc(); m2 = 1'b0;
    chk("paused_p1", 32'(p1), 32'(exp_p1));
    chk("paused_p2", 32'(p2), 32'(exp_p2));
    chk("paused_state", 32'(st), 4);
    frames(100);
    press(1'b1, 3'd1, "unpause_serve_wait");
    frames(SD - 30 - 1);
    repeat (3) cyc();
    chk("unpause_hold_state", 32'(st), 1);
    eof = 1'b1; cyc(); eof = 1'b0;
    chk("unpause_rally", 32'(st), 2);

    do_hits($urandom_range(0, 12), 1'b0);
    press(1'b1, 3'd4, "pause_rally");
    chk("pause_speed_held", 32'(spd), 32'(lvl(hits)));
    h2 = 1'b1; cyc(); h2 = 1'b0;
    press(1'b1, 3'd2, "unpause_rally");
    chk("unpause_run", 32'(run), 1);
    chk("pause_hit_ignored", 32'(spd), 32'(lvl(hits)));
    bst = 1'b1; repeat (8) cyc(); bst = 1'b0; repeat (4) cyc();
    chk("start_in_rally_ignored", 32'(st), 2);

    m1 = 1'b1; m2 = 1'b1; cyc(); m1 = 1'b0; m2 = 1'b0;
    chk("double_miss_state", 32'(st), 1);
    chk("double_miss_p1", 32'(p1), 32'(exp_p1));
    chk("double_miss_p2", 32'(p2), 32'(exp_p2));
    serve();
    do_hits($urandom_range(1, 6), 1'b0);

    while (exp_p1 < WIN && exp_p2 < WIN) begin
      who = $urandom_range(1, 2);
      miss(who);
      point_hold();
      if (st === 3'd1) begin
        serve();
        n = $urandom_range(0, 10);
        do_hits(n, 1'b0);
      end else if (st !== 3'd5) begin
        break;
      end
    end

    press(1'b0, 3'd1, "restart_game");
    exp_p1 = 0; exp_p2 = 0; exp_dir = 1; hits = 0;
    chk("restart_p1", 32'(p1), 0);
    chk("restart_p2", 32'(p2), 0);
    chk("restart_dir", 32'(dir), 1);
    chk("restart_go", 32'(go), 0);
    serve();
    for (int i = 0; i < WIN; i++) begin
      do_hits($urandom_range(0, 5), 1'b0);
      miss(1);
      point_hold();
      if (i < WIN - 1) serve();
    end
    chk("p2_wins", 32'(win), 1);
    chk("final_p2", 32'(p2), WIN);

    press(1'b0, 3'd1, "restart_game2");
    exp_p1 = 0; exp_p2 = 0; exp_dir = 1; hits = 0;
    serve();
    miss(2);
    point_hold();
    serve();
    do_hits(5, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(st), 0);
    chk("async_rst_p1", 32'(p1), 0);
    chk("async_rst_speed", 32'(spd), 0);
    chk("async_rst_run", 32'(run), 0);
    chk("async_rst_dir", 32'(dir), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
